codma_bus_arbiter: RTL and testbench

- Shares the single system bus interface between the CODMA read channel and write channel.
- Accepts burst requests from each channel and arbitrates round-robin.
- Requests the bus, grants the winning channel, and counts data beats to the programmed burst length.
- Releases the bus on completion, bus error or beat timeout, and reports done/error to the channel that owned the transfer.

---
 rtl/codma_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_codma_bus_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codma_bus_arbiter.sv
// Round-robin arbiter sharing one system bus between the CODMA read and
// write channels; counts beats per burst and reports done/error.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   rd_req_i, rd_len_i        read channel burst request and length
//   rd_grant_o                read channel owns the bus (transfer phase)
//   rd_done_o, rd_error_o     read burst finished / finished abnormally
//   wr_req_i, wr_len_i        write channel burst request and length
//   wr_grant_o                write channel owns the bus
//   wr_done_o, wr_error_o     write burst finished / finished abnormally
//   bus_req_o, bus_write_o    bus request, owner is the write channel
//   bus_grant_i               bus accepts the request
//   bus_beat_i, bus_error_i   one word moved / bus error this cycle
//   beat_cnt_o                beats completed in the current burst
module codma_bus_arbiter #(
    parameter int MAX_BURST      = 8,
    parameter int LEN_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             rd_req_i,
    input  logic [LEN_W-1:0] rd_len_i,
    output logic             rd_grant_o,
    output logic             rd_done_o,
    output logic             rd_error_o,
    input  logic             wr_req_i,
    input  logic [LEN_W-1:0] wr_len_i,
    output logic             wr_grant_o,
    output logic             wr_done_o,
    output logic             wr_error_o,
    output logic             bus_req_o,
    output logic             bus_write_o,
    input  logic             bus_grant_i,
    input  logic             bus_beat_i,
    input  logic             bus_error_i,
    output logic [LEN_W-1:0] beat_cnt_o
);

    localparam int TMO_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TMO_END =
        (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BURST);
    localparam logic [LEN_W-1:0] ONE_LEN  = LEN_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_END);
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        XFER,
        DONE
    } state_t;

    state_t           state_q, state_d;
    // owner / last_owner: 1 = write channel, 0 = read channel
    logic             owner_q, owner_d;
    logic             last_owner_q;
    logic             err_q, err_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic             pick_wr;
    logic [LEN_W-1:0] sel_len;
    logic [LEN_W-1:0] clamp_len;
    logic             owner_req;
    logic             last_beat;
    logic             timeout_hit;

    // On a tie the channel that did not own the last burst wins.
    assign pick_wr   = wr_req_i && (!rd_req_i || !last_owner_q);
    assign sel_len   = pick_wr ? wr_len_i : rd_len_i;
    assign owner_req = owner_q ? wr_req_i : rd_req_i;
    assign last_beat = (cnt_q + ONE_LEN) == len_q;

    always_comb begin
        clamp_len = sel_len;
        if (sel_len == '0) begin
            clamp_len = ONE_LEN;
        end else if (sel_len > MAX_LEN) begin
            clamp_len = MAX_LEN;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive beatless XFER cycle.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        err_d   = err_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (rd_req_i || wr_req_i) begin
                    owner_d = pick_wr;
                    len_d   = clamp_len;
                    state_d = ARB;
                end
            end
            ARB: begin
                if (bus_grant_i) begin
                    cnt_d   = '0;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                    state_d = XFER;
                end else if (!owner_req) begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                // An error outranks a beat arriving in the same cycle.
                if (bus_error_i) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (bus_beat_i) begin
                    tmo_d = '0;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + ONE_LEN;
                    end
                    if (last_beat) begin
                        err_d   = 1'b0;
                        state_d = DONE;
                    end
                end else begin
                    if (tmo_q != TMO_MAX) begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                    if (timeout_hit) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            err_q        <= 1'b0;
            len_q        <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            if (state_q == DONE) begin
                last_owner_q <= owner_q;
            end
        end
    end

    // Outputs decode straight from state so reset clears them at once.
    assign rd_grant_o  = (state_q == XFER) && !owner_q;
    assign wr_grant_o  = (state_q == XFER) && owner_q;
    assign rd_done_o   = (state_q == DONE) && !owner_q;
    assign wr_done_o   = (state_q == DONE) && owner_q;
    assign rd_error_o  = rd_done_o && err_q;
    assign wr_error_o  = wr_done_o && err_q;
    assign bus_req_o   = (state_q == ARB) || (state_q == XFER);
    assign bus_write_o = (state_q != IDLE) && owner_q;
    assign beat_cnt_o  = cnt_q;

endmodule

// File: tb/tb_codma_bus_arbiter.sv
// Self-checking bench for codma_bus_arbiter: directed scenarios plus
// randomized bursts checked against a burst-level reference model.
module tb_codma_bus_arbiter;

    localparam int LEN_W     = 4;
    localparam int MAX_BURST = 8;
    localparam int TMO       = 64;
    localparam int PLAN_N    = 256;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             rd_req = 1'b0;
    logic [LEN_W-1:0] rd_len = '0;
    logic             rd_grant, rd_done, rd_error;
    logic             wr_req = 1'b0;
    logic [LEN_W-1:0] wr_len = '0;
    logic             wr_grant, wr_done, wr_error;
    logic             bus_req, bus_write;
    logic             bus_grant = 1'b0;
    logic             bus_beat = 1'b0;
    logic             bus_error = 1'b0;
    logic [LEN_W-1:0] beat_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit model_last_wr;
    bit plan_beat [PLAN_N];
    bit plan_err  [PLAN_N];

    always #5 clk = ~clk;

    codma_bus_arbiter #(
        .MAX_BURST(MAX_BURST),
        .LEN_W(LEN_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .rd_req_i(rd_req),
        .rd_len_i(rd_len),
        .rd_grant_o(rd_grant),
        .rd_done_o(rd_done),
        .rd_error_o(rd_error),
        .wr_req_i(wr_req),
        .wr_len_i(wr_len),
        .wr_grant_o(wr_grant),
        .wr_done_o(wr_done),
        .wr_error_o(wr_error),
        .bus_req_o(bus_req),
        .bus_write_o(bus_write),
        .bus_grant_i(bus_grant),
        .bus_beat_i(bus_beat),
        .bus_error_i(bus_error),
        .beat_cnt_o(beat_cnt)
    );

    function automatic logic [11:0] all_outs();
        return {rd_grant, rd_done, rd_error, wr_grant, wr_done,
                wr_error, bus_req, bus_write, beat_cnt};
    endfunction

    function automatic int eff_len(input int l);
        if (l == 0) return 1;
        if (l > MAX_BURST) return MAX_BURST;
        return l;
    endfunction

    task automatic clear_plan();
        for (int k = 0; k < PLAN_N; k++) begin
            plan_beat[k] = 1'b0;
            plan_err[k]  = 1'b0;
        end
    endtask

    task automatic plan_beats(input int n);
        clear_plan();
        for (int k = 0; k < n; k++) plan_beat[k] = 1'b1;
    endtask

    // Walks the per-cycle bus plan: first error, reaching len,
    // or TMO consecutive silent cycles ends the burst.
    task automatic model_burst(input int len, output int end_k,
                               output bit e_err, output int e_cnt);
        int cnt;
        int gap;
        cnt   = 0;
        gap   = 0;
        end_k = -1;
        e_err = 1'b0;
        e_cnt = 0;
        for (int k = 0; k < PLAN_N; k++) begin
            if (plan_err[k]) begin
                end_k = k; e_err = 1'b1; e_cnt = cnt;
                return;
            end
            if (plan_beat[k]) begin
                cnt++;
                gap = 0;
                if (cnt == len) begin
                    end_k = k; e_cnt = cnt;
                    return;
                end
            end else begin
                gap++;
                if (gap == TMO) begin
                    end_k = k; e_err = 1'b1; e_cnt = cnt;
                    return;
                end
            end
        end
    endtask

    task automatic do_burst(input bit r, input bit w, input int rl,
                            input int wl, input int gdly,
                            input string tag);
        bit exp_wr;
        bit e_err;
        bit finished;
        int len, end_k, e_cnt;
        int arb_n, xk, run_cnt;
        logic [3:0] exp_dn;
        logic [3:0] got_dn;
        exp_wr   = w && (!r || !model_last_wr);
        len      = eff_len(exp_wr ? wl : rl);
        model_burst(len, end_k, e_err, e_cnt);
        finished = 1'b0;
        arb_n    = 0;
        xk       = 0;
        run_cnt  = 0;
        rd_req   = r;
        wr_req   = w;
        rd_len   = LEN_W'(rl);
        wr_len   = LEN_W'(wl);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            bus_grant = 1'b0;
            bus_beat  = 1'b0;
            bus_error = 1'b0;
            if (rd_done || wr_done) begin
                finished = 1'b1;
                exp_dn = exp_wr ? {2'b00, 1'b1, e_err}
                                : {1'b1, e_err, 2'b00};
                got_dn = {rd_done, rd_error, wr_done, wr_error};
                n_tests++;
                if (got_dn !== exp_dn) begin
                    n_fail++;
                    $display("FAIL %s done_err got=%b exp=%b",
                             tag, got_dn, exp_dn);
                end
                n_tests++;
                if (beat_cnt !== LEN_W'(e_cnt)) begin
                    n_fail++;
                    $display("FAIL %s beat_cnt got=%0d exp=%0d",
                             tag, beat_cnt, e_cnt);
                end
                n_tests++;
                if (xk !== end_k + 1) begin
                    n_fail++;
                    $display("FAIL %s grant_cycles got=%0d exp=%0d",
                             tag, xk, end_k + 1);
                end
                n_tests++;
                if ({bus_req, rd_grant, wr_grant} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL %s done_bus got=%b exp=000", tag,
                             {bus_req, rd_grant, wr_grant});
                end
                if (exp_wr) wr_req = 1'b0;
                else rd_req = 1'b0;
                model_last_wr = exp_wr;
            end else if (rd_grant || wr_grant) begin
                n_tests++;
                if ({rd_grant, wr_grant, bus_write, bus_req} !==
                    {!exp_wr, exp_wr, exp_wr, 1'b1}) begin
                    n_fail++;
                    $display("FAIL %s xfer_owner got=%b exp=%b", tag,
                             {rd_grant, wr_grant, bus_write, bus_req},
                             {!exp_wr, exp_wr, exp_wr, 1'b1});
                end
                n_tests++;
                if (beat_cnt !== LEN_W'(run_cnt)) begin
                    n_fail++;
                    $display("FAIL %s run_cnt got=%0d exp=%0d",
                             tag, beat_cnt, run_cnt);
                end
                if (xk < PLAN_N) begin
                    bus_beat  = plan_beat[xk];
                    bus_error = plan_err[xk];
                    if (plan_beat[xk] && !plan_err[xk]) run_cnt++;
                end
                xk++;
            end else if (bus_req) begin
                n_tests++;
                if (bus_write !== exp_wr) begin
                    n_fail++;
                    $display("FAIL %s arb_write got=%b exp=%b",
                             tag, bus_write, exp_wr);
                end
                arb_n++;
                bus_grant = (arb_n > gdly);
                bus_beat  = 1'($urandom_range(0, 1));
            end
        end
        n_tests++;
        if (!finished) begin
            n_fail++;
            $display("FAIL %s no_done got=none exp=done", tag);
        end else begin
            @(posedge clk);
            @(negedge clk);
            if ({bus_req, rd_grant, wr_grant, rd_done, wr_done}
                !== 5'b0) begin
                n_fail++;
                $display("FAIL %s turnaround got=%b exp=00000", tag,
                         {bus_req, rd_grant, wr_grant, rd_done,
                          wr_done});
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (all_outs() !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_async got=%h exp=000", all_outs());
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (all_outs() !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_hold got=%h exp=000", all_outs());
        end
        reset_n       = 1'b1;
        model_last_wr = 1'b1;
    endtask

    task automatic test_single_read();
        plan_beats(8);
        do_burst(1'b1, 1'b0, 8, 0, 2, "rd_len8");
    endtask

    task automatic test_tie();
        plan_beats(4);
        for (int i = 0; i < 4; i++) begin
            do_burst(1'b1, 1'b1, 4, 4, 1, "tie");
        end
    endtask

    task automatic test_bus_error();
        plan_beats(3);
        plan_err[2] = 1'b1;
        do_burst(1'b0, 1'b1, 0, 8, 0, "wr_err");
        plan_beats(3);
        do_burst(1'b1, 1'b1, 3, 3, 1, "after_err");
    endtask

    task automatic test_timeout();
        plan_beats(1);
        do_burst(1'b1, 1'b0, 4, 0, 1, "timeout");
    endtask

    task automatic test_len_edge();
        plan_beats(PLAN_N);
        do_burst(1'b1, 1'b0, 0, 0, 0, "len0");
        do_burst(1'b1, 1'b0, 15, 0, 1, "len15");
    endtask

    task automatic test_abort();
        int arb_n;
        arb_n  = 0;
        rd_req = 1'b1;
        wr_req = 1'b0;
        rd_len = LEN_W'(4);
        for (int c = 0; c < 10 && arb_n < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_req) arb_n++;
        end
        rd_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (arb_n != 2 ||
            {bus_req, rd_grant, rd_done, wr_done} !== 4'b0) begin
            n_fail++;
            $display("FAIL abort got=%b arb=%0d exp=0000 arb=2",
                     {bus_req, rd_grant, rd_done, wr_done}, arb_n);
        end
        plan_beats(2);
        do_burst(1'b1, 1'b1, 2, 2, 0, "post_abort");
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit    = 1'b0;
        rd_req = 1'b1;
        wr_req = 1'b0;
        rd_len = LEN_W'(8);
        for (int c = 0; c < 40 && !hit; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus_grant = 1'b0;
            bus_beat  = 1'b0;
            if (rd_grant) begin
                bus_beat = 1'b1;
                if (beat_cnt == LEN_W'(4)) hit = 1'b1;
            end else if (bus_req) begin
                bus_grant = 1'b1;
            end
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL rst_mid_reach got=none exp=beat5");
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (all_outs() !== 12'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async got=%h exp=000", all_outs());
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (all_outs() !== 12'b0) begin
            n_fail++;
            $display("FAIL rst_mid_hold got=%h exp=000", all_outs());
        end
        bus_beat      = 1'b0;
        bus_grant     = 1'b0;
        rd_req        = 1'b0;
        reset_n       = 1'b1;
        model_last_wr = 1'b1;
        plan_beats(4);
        do_burst(1'b1, 1'b1, 4, 4, 0, "rst_tie");
    endtask

    task automatic test_random();
        bit r, w;
        for (int i = 0; i < 40; i++) begin
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (!r && !w) r = 1'b1;
            clear_plan();
            for (int k = 0; k < 30; k++) begin
                plan_beat[k] = ($urandom_range(0, 3) != 0);
                plan_err[k]  = ($urandom_range(0, 39) == 0);
            end
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 2; k < 30; k++) plan_beat[k] = 1'b0;
            end
            do_burst(r, w, int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        #2 reset_n = 1'b0;
        test_reset();
        test_single_read();
        test_tie();
        test_bus_error();
        test_timeout();
        test_abort();
        test_len_edge();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
